// File: rtl/uio_bus_arbiter_if.sv
// Signal bundle between the uio pad arbiter and its requesters / pads.
// The arbiter side uses the slave modport; requesters and pads use master.
interface uio_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: a requester holds req[i] high (level) for as long as it wants
    // the bus. The arbiter answers with a registered one-hot grant. The owner
    // may touch the bus only while grant[i] is high. It gives the bus back by
    // pulsing done[i] or by dropping req[i]. Either takes effect at the next
    // clock edge. dir[i] is sampled once, at the arbitration edge that picks
    // requester i.
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   dir;
    logic [NUM_REQ-1:0]   done;
    logic [8*NUM_REQ-1:0] wdata;
    logic [7:0]           uio_in;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [7:0]           rdata;
    logic                 rvalid;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;
    logic [1:0]           dbg_state;

    modport slave (
        input  req, dir, done, wdata, uio_in,
        output grant, busy, rdata, rvalid, uio_out, uio_oe, dbg_state
    );

    modport master (
        output req, dir, done, wdata, uio_in,
        input  grant, busy, rdata, rvalid, uio_out, uio_oe, dbg_state
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus, with hold limit and turnaround gap.
// Optional macro UIO_ARB_PRIORITY_EN: requester 0 gets fixed priority and is never preempted.
module uio_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    uio_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               owner_dir_q, owner_dir_d;
    logic               last_dir_q, last_dir_d;
    logic [7:0]         hold_q, hold_d;
    logic [1:0]         turn_q, turn_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               rvalid_q, rvalid_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [7:0]         uio_out_q, uio_out_d;
    logic [7:0]         uio_oe_q, uio_oe_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      win_next_ptr;
    logic [IW:0]        scan_sum;
    logic [IW-1:0]      scan_idx;
    logic               preempt;
    logic               release_own;
    logic               do_arb;

    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign others   = bus.req & ~owner_oh;

    // At a release the old owner may win again only when nobody else is asking.
    assign cand = (state_q == ST_OWN && (|others)) ? others : bus.req;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
`ifdef UIO_ARB_PRIORITY_EN
        if (cand[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ)) scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            scan_idx = scan_sum[IW-1:0];
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_next_ptr = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + IW'(1);
`ifdef UIO_ARB_PRIORITY_EN
        // Requester 0 sits outside the rotation, so the pointer never lands on it.
        if (win_idx == '0)           win_next_ptr = rr_ptr_q;
        else if (win_next_ptr == '0) win_next_ptr = IW'(1);
`endif
    end

    always_comb begin
        preempt = (hold_q == 8'(MAX_HOLD)) && (|others);
`ifdef UIO_ARB_PRIORITY_EN
        if (owner_q == '0) preempt = 1'b0;
`endif
        release_own = bus.done[owner_q] | ~bus.req[owner_q] | preempt;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        owner_dir_d = owner_dir_q;
        last_dir_d  = last_dir_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        do_arb      = 1'b0;

        if (!ena) begin
            state_d    = ST_IDLE;
            last_dir_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: do_arb = 1'b1;
                ST_TURN: begin
                    if (turn_q == 2'd0) begin
                        state_d = ST_OWN;
                        hold_d  = 8'd1;
                    end else begin
                        turn_d = turn_q - 2'd1;
                    end
                end
                ST_OWN: begin
                    rdata_d  = bus.uio_in;
                    rvalid_d = ~owner_dir_q;
                    if (release_own) begin
                        do_arb = 1'b1;
                        if (!win_found) begin
                            state_d    = ST_IDLE;
                            last_dir_d = 1'b0;
                        end
                    end else if (hold_q != 8'(MAX_HOLD)) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_arb && win_found) begin
                owner_d     = win_idx;
                rr_ptr_d    = win_next_ptr;
                owner_dir_d = bus.dir[win_idx];
                last_dir_d  = bus.dir[win_idx];
                // A direction change parks the bus for TURNAROUND cycles first.
                if (bus.dir[win_idx] != last_dir_q) begin
                    state_d = ST_TURN;
                    turn_d  = 2'(TURNAROUND - 1);
                end else begin
                    state_d = ST_OWN;
                    hold_d  = 8'd1;
                end
            end
        end
    end

    // Registered outputs follow the next state so grant and pad data appear together.
    always_comb begin
        grant_d   = '0;
        uio_oe_d  = 8'h00;
        uio_out_d = 8'h00;
        busy_d    = (state_d != ST_IDLE);
        if (state_d == ST_OWN) begin
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_d;
            if (owner_dir_d) begin
                uio_oe_d  = 8'hFF;
                uio_out_d = bus.wdata[8*owner_d +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            owner_dir_q <= 1'b0;
            last_dir_q  <= 1'b0;
            hold_q      <= 8'd0;
            turn_q      <= 2'd0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 8'h00;
            uio_out_q   <= 8'h00;
            uio_oe_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_dir_q <= owner_dir_d;
            last_dir_q  <= last_dir_d;
            hold_q      <= hold_d;
            turn_q      <= turn_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            uio_out_q   <= uio_out_d;
            uio_oe_q    <= uio_oe_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.uio_out   = uio_out_q;
    assign bus.uio_oe    = uio_oe_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: scenario tasks with a grant/count scoreboard queue.
// Build with +define+UIO_ARB_PRIORITY_EN to exercise the priority variant.
module tb_uio_bus_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    uio_bus_arbiter_if #(.NUM_REQ(N)) bus ();

    uio_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(8), .TURNAROUND(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req    = '0;
        bus.dir    = '0;
        bus.done   = '0;
        bus.wdata  = '0;
        bus.uio_in = 8'h00;
    endtask

    task automatic do_reset();
        drive_idle();
        ena   = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_grant(input string name);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        vec_cnt++;
        if ({4'b0, bus.grant} !== exp) begin
            err_cnt++;
            $display("FAIL %s: grant=%b expected=%b", name, bus.grant, exp[N-1:0]);
        end
    endtask

    task automatic test_reset();
        bit found;
        do_reset();
        vec_cnt++;
        if ({bus.grant, bus.busy, bus.rvalid} !== '0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: grant=%b busy=%b rvalid=%b expected 0", bus.grant, bus.busy, bus.rvalid);
        end
        vec_cnt++;
        if ({bus.uio_oe, bus.uio_out, bus.rdata} !== 24'h0) begin
            err_cnt++;
            $display("FAIL reset_data: oe=%h out=%h rdata=%h expected 0", bus.uio_oe, bus.uio_out, bus.rdata);
        end
        bus.req = 4'b0100;
        bus.dir = 4'b0100;
        bus.wdata[23:16] = 8'h3C;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (bus.uio_oe === 8'hFF) found = 1'b1;
        end
        vec_cnt++;
        if (!found) begin
            err_cnt++;
            $display("FAIL reset_reach_own: oe=%h expected ff within 10 cycles", bus.uio_oe);
        end
        #3 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.uio_oe !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_async_oe: oe=%h expected 00", bus.uio_oe);
        end
        vec_cnt++;
        if ({bus.grant, bus.busy, bus.rvalid} !== '0) begin
            err_cnt++;
            $display("FAIL reset_async_ctrl: grant=%b busy=%b rvalid=%b expected 0", bus.grant, bus.busy, bus.rvalid);
        end
        bus.req   = 4'b1111;
        bus.dir   = 4'b0000;
        bus.wdata = '0;
        #1 rst_n = 1'b1;
        exp_q.push_back(8'h01);
        tick();
        check_grant("reset_first_grant");
    endtask

    task automatic test_listen();
        do_reset();
        bus.req    = 4'b0010;
        bus.uio_in = 8'hA5;
        exp_q.push_back(8'h02);
        tick();
        check_grant("listen_grant");
        vec_cnt++;
        if ({bus.uio_oe, bus.busy, bus.rvalid} !== {8'h00, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL listen_first: oe=%h busy=%b rvalid=%b expected 00 1 0", bus.uio_oe, bus.busy, bus.rvalid);
        end
        tick();
        vec_cnt++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 8'hA5}) begin
            err_cnt++;
            $display("FAIL listen_rdata: rvalid=%b rdata=%h expected 1 a5", bus.rvalid, bus.rdata);
        end
        bus.req = 4'b0000;
        tick();
        vec_cnt++;
        if ({bus.grant, bus.rvalid} !== {4'b0000, 1'b1}) begin
            err_cnt++;
            $display("FAIL listen_release: grant=%b rvalid=%b expected 0000 1", bus.grant, bus.rvalid);
        end
        tick();
        vec_cnt++;
        if ({bus.busy, bus.rvalid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL listen_idle: busy=%b rvalid=%b expected 0 0", bus.busy, bus.rvalid);
        end
    endtask

    task automatic test_drive();
        logic [7:0] d0;
        logic [7:0] d1;
        do_reset();
        d0 = 8'h3C;
        d1 = 8'($urandom_range(1, 255));
        bus.req = 4'b0100;
        bus.dir = 4'b0100;
        bus.wdata[23:16] = d0;
        tick();
        vec_cnt++;
        if ({bus.busy, bus.grant, bus.uio_oe} !== {1'b1, 4'b0000, 8'h00}) begin
            err_cnt++;
            $display("FAIL drive_turn: busy=%b grant=%b oe=%h expected 1 0000 00", bus.busy, bus.grant, bus.uio_oe);
        end
        exp_q.push_back(8'h04);
        tick();
        check_grant("drive_grant");
        vec_cnt++;
        if ({bus.uio_oe, bus.uio_out} !== {8'hFF, d0}) begin
            err_cnt++;
            $display("FAIL drive_pins: oe=%h out=%h expected ff %h", bus.uio_oe, bus.uio_out, d0);
        end
        bus.wdata[23:16] = d1;
        tick();
        vec_cnt++;
        if (bus.uio_out !== d1) begin
            err_cnt++;
            $display("FAIL drive_follow: out=%h expected %h", bus.uio_out, d1);
        end
        bus.req = 4'b0000;
        tick();
        vec_cnt++;
        if ({bus.busy, bus.uio_oe, bus.uio_out} !== {1'b0, 8'h00, 8'h00}) begin
            err_cnt++;
            $display("FAIL drive_release: busy=%b oe=%h out=%h expected 0 00 00", bus.busy, bus.uio_oe, bus.uio_out);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev;
        logic [7:0]   exp;
        do_reset();
        bus.req = 4'b1111;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h01);
        prev = '0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            tick();
            bus.done = '0;
            if (bus.grant === '0) begin
                if (prev !== '0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL rr_gap: grant=%b expected next owner without gap", bus.grant);
                end
            end else if (bus.grant !== prev) begin
                exp = exp_q.pop_front();
                vec_cnt++;
                if ({4'b0, bus.grant} !== exp) begin
                    err_cnt++;
                    $display("FAIL rr_order: grant=%b expected=%b", bus.grant, exp[N-1:0]);
                end
                prev = bus.grant;
            end else begin
                bus.done = bus.grant;
            end
        end
        bus.done = '0;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL rr_timeout: %0d grants outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_preempt(input logic d2);
        int cnt;
        bit run;
        logic [7:0] exp;
        do_reset();
        bus.req = 4'b0110;
        bus.dir = {1'b0, d2, 2'b00};
        exp_q.push_back(8'h02);
        tick();
        check_grant("preempt_first");
        cnt = 1;
        run = 1'b1;
        for (int c = 0; c < 20 && run; c++) begin
            tick();
            if (bus.grant === 4'b0010) cnt++;
            else run = 1'b0;
        end
        exp_q.push_back(8'd8);
        exp = exp_q.pop_front();
        vec_cnt++;
        if (8'(cnt) !== exp) begin
            err_cnt++;
            $display("FAIL preempt_hold: held=%0d cycles expected=%0d", cnt, exp);
        end
        if (d2) begin
            vec_cnt++;
            if ({bus.busy, bus.grant, bus.uio_oe} !== {1'b1, 4'b0000, 8'h00}) begin
                err_cnt++;
                $display("FAIL preempt_turn: busy=%b grant=%b oe=%h expected 1 0000 00", bus.busy, bus.grant, bus.uio_oe);
            end
            tick();
        end
        exp_q.push_back(8'h04);
        check_grant(d2 ? "preempt_next_drive" : "preempt_next_listen");
    endtask

    task automatic test_ownership_rules();
        do_reset();
        bus.req = 4'b0011;
        exp_q.push_back(8'h01);
        tick();
        check_grant("rules_first");
        bus.done = 4'b0010;
        bus.dir  = 4'b0001;
        exp_q.push_back(8'h01);
        tick();
        check_grant("rules_nonowner_done");
        vec_cnt++;
        if (bus.uio_oe !== 8'h00) begin
            err_cnt++;
            $display("FAIL rules_dir_change: oe=%h expected 00", bus.uio_oe);
        end
        bus.done = 4'b0001;
        bus.dir  = 4'b0000;
        exp_q.push_back(8'h02);
        tick();
        check_grant("rules_done_handoff");
        bus.done = 4'b0010;
        exp_q.push_back(8'h01);
        tick();
        check_grant("rules_min_own");
        bus.done = '0;
    endtask

    task automatic test_ena();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        ena = 1'b0;
        tick();
        vec_cnt++;
        if ({bus.grant, bus.busy, bus.rvalid, bus.uio_oe} !== '0) begin
            err_cnt++;
            $display("FAIL ena_off: grant=%b busy=%b rvalid=%b oe=%h expected 0", bus.grant, bus.busy, bus.rvalid, bus.uio_oe);
        end
        ena = 1'b1;
        bus.req = 4'b1111;
`ifdef UIO_ARB_PRIORITY_EN
        exp_q.push_back(8'h01);
`else
        exp_q.push_back(8'h04);
`endif
        tick();
        check_grant("ena_rr_retained");
    endtask

`ifdef UIO_ARB_PRIORITY_EN
    task automatic test_priority();
        int held;
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        bus.req = 4'b1101;
        exp_q.push_back(8'h01);
        tick();
        check_grant("prio_first");
        held = 1;
        for (int c = 0; c < 19; c++) begin
            tick();
            if (bus.grant === 4'b0001) held++;
        end
        vec_cnt++;
        if (held != 20) begin
            err_cnt++;
            $display("FAIL prio_hold: held=%0d expected 20", held);
        end
        bus.done = 4'b0001;
        exp_q.push_back(8'h04);
        tick();
        bus.done = '0;
        check_grant("prio_after_done");
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        drive_idle();
        test_reset();
        test_listen();
        test_drive();
        test_round_robin();
        test_preempt(1'b0);
        test_preempt(1'b1);
        test_ownership_rules();
        test_ena();
`ifdef UIO_ARB_PRIORITY_EN
        test_priority();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
